gin_tag_receiver: RTL

GIN_TAG_RECEIVER -- requirements
Module: gin_tag_receiver

---
 rtl/gin_tag_receiver_if.sv | 34 +++
 rtl/gin_tag_receiver.sv | 98 +++++++++
 2 files changed

// File: rtl/gin_tag_receiver_if.sv
// Tag/data FIFO, row/column ID and PE-side signals of the GIN tag receiver.
// master drives the FIFOs and PE readiness; slave is the receiver itself.
interface gin_tag_receiver_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 5,
  parameter int NUM_PE        = 14
);
  logic [ROW_TAG_WIDTH-1:0]        row_id;
  logic [NUM_PE*COL_TAG_WIDTH-1:0] col_ids;
  logic                            tags_fifo_empty;
  logic                            re_tags;
  logic [ROW_TAG_WIDTH-1:0]        row_tag;
  logic [COL_TAG_WIDTH-1:0]        col_tag;
  logic                            data_fifo_empty;
  logic                            re_data;
  logic [DATA_WIDTH-1:0]           din;
  logic [NUM_PE-1:0]               pe_ready;
  logic [NUM_PE-1:0]               pe_we;
  logic [DATA_WIDTH-1:0]           dout;
  logic                            busy;

  modport master (
    output row_id, col_ids, tags_fifo_empty, row_tag, col_tag,
           data_fifo_empty, din, pe_ready,
    input  re_tags, re_data, pe_we, dout, busy
  );

  modport slave (
    input  row_id, col_ids, tags_fifo_empty, row_tag, col_tag,
           data_fifo_empty, din, pe_ready,
    output re_tags, re_data, pe_we, dout, busy
  );
endinterface

// File: rtl/gin_tag_receiver.sv
// GIN tag receiver: pops (tag, payload) pairs and delivers the payload to
// every PE whose (row, col) ID matches. Define TAG_BROADCAST_EN to make an
// all-ones column tag match every PE in the addressed row.

module gin_tag_match_lane #(
  parameter int COL_TAG_WIDTH = 5
) (
  input  logic                     row_hit,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  input  logic [COL_TAG_WIDTH-1:0] col_id,
  output logic                     hit
);
`ifdef TAG_BROADCAST_EN
  assign hit = row_hit && ((col_tag == col_id) || (&col_tag));
`else
  assign hit = row_hit && (col_tag == col_id);
`endif
endmodule

module gin_tag_receiver #(
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 5,
  parameter int NUM_PE        = 14
) (
  input  logic              clk,
  input  logic              reset,
  gin_tag_receiver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DELIVER} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_PE-1:0]     match_q, match_d;
  logic                  fifos_avail;
  logic                  row_hit;
  logic                  deliver_ok;
  logic                  fetch;

  assign fifos_avail = ~bus.tags_fifo_empty & ~bus.data_fifo_empty;
  assign row_hit     = (bus.row_tag == bus.row_id);

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    gin_tag_match_lane #(.COL_TAG_WIDTH(COL_TAG_WIDTH)) u_lane (
      .row_hit (row_hit),
      .col_tag (bus.col_tag),
      .col_id  (bus.col_ids[i*COL_TAG_WIDTH +: COL_TAG_WIDTH]),
      .hit     (match_d[i])
    );
  end

  // An all-zero match makes the ready test trivially true, so a dropped
  // packet retires through the same path as a delivered one.
  always_comb begin
    state_d    = state_q;
    fetch      = 1'b0;
    deliver_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifos_avail) begin
          fetch   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = DELIVER;
      DELIVER: begin
        deliver_ok = &(bus.pe_ready | ~match_q);
        if (deliver_ok) begin
          fetch   = fifos_avail;
          state_d = fifos_avail ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LOAD) begin
        data_q  <= bus.din;
        match_q <= match_d;
      end
    end
  end

  // Outputs are forced quiet for the whole reset cycle, even if the state
  // register still holds LOAD/DELIVER until the edge.
  assign bus.re_tags = fetch & ~reset;
  assign bus.re_data = fetch & ~reset;
  assign bus.pe_we   = (state_q == DELIVER && deliver_ok && !reset) ? match_q : '0;
  assign bus.dout    = reset ? '0 : data_q;
  assign bus.busy    = (state_q != IDLE) & ~reset;
endmodule
